data_mem_txn_capture: RTL and testbench

DATA_MEM_TXN_CAPTURE -- requirements
Module: data_mem_txn_capture

---
 rtl/data_mem_txn_capture_if.sv | 36 +++
 rtl/data_mem_txn_capture.sv | 108 ++++++++++
 tb/tb_data_mem_txn_capture.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_txn_capture_if.sv
// Bus bundle for the data-memory transaction capture block: capture-side inputs
// and the show-ahead FIFO head/status outputs.
interface data_mem_txn_capture_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned STAMP_W = 16
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic                complete_data;
  logic                Data_rd;
  logic [ADDR_W-1:0]   Data_addr;
  logic [DATA_W-1:0]   Data_din;
  logic [DATA_W-1:0]   Data_dout;
  logic                enable;
  logic                pop;
  logic                txn_valid;
  logic                txn_rd;
  logic [ADDR_W-1:0]   txn_addr;
  logic [DATA_W-1:0]   txn_data;
  logic [STAMP_W-1:0]  txn_stamp;
  logic [LVL_W-1:0]    level;
  logic                full;
  logic [15:0]         drop_cnt;

  modport master (
    output complete_data, Data_rd, Data_addr, Data_din, Data_dout, enable, pop,
    input  txn_valid, txn_rd, txn_addr, txn_data, txn_stamp, level, full, drop_cnt
  );

  modport slave (
    input  complete_data, Data_rd, Data_addr, Data_din, Data_dout, enable, pop,
    output txn_valid, txn_rd, txn_addr, txn_data, txn_stamp, level, full, drop_cnt
  );
endinterface

// File: rtl/data_mem_txn_capture.sv
// Captures completed data-memory accesses (rising edge of complete_data) with a
// cycle stamp into a show-ahead FIFO; overflowing captures are counted and dropped.
module data_mem_txn_capture #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned STAMP_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  data_mem_txn_capture_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic               rd;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head_q;
  logic               prev_q;
  logic [STAMP_W-1:0] stamp_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic [15:0]        drop_q;

  logic               full_c;
  logic               event_c;
  logic               pop_c;
  logic               push_c;
  logic               drop_c;
  entry_t             new_entry_c;
  entry_t             head_n_c;
  logic [PTR_W-1:0]   wr_ptr_n_c;
  logic [PTR_W-1:0]   rd_ptr_n_c;
  logic [LVL_W-1:0]   level_n_c;

  assign full_c  = (level_q == LVL_W'(DEPTH));
  assign event_c = bus.complete_data & ~prev_q & bus.enable;
  assign pop_c   = bus.pop & (level_q != '0);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
  assign push_c  = event_c & (~full_c | pop_c);
  assign drop_c  = event_c & full_c & ~pop_c;

  // Next-state pointers, level and the registered head entry.
  always_comb begin
    new_entry_c       = '0;
    new_entry_c.rd    = bus.Data_rd;
    new_entry_c.addr  = bus.Data_addr;
    new_entry_c.data  = bus.Data_rd ? bus.Data_dout : bus.Data_din;
    new_entry_c.stamp = stamp_q;

    wr_ptr_n_c = wr_ptr_q;
    rd_ptr_n_c = rd_ptr_q;
    level_n_c  = level_q;
    if (push_c) wr_ptr_n_c = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_n_c = rd_ptr_q + PTR_W'(1);
    if (push_c && !pop_c)      level_n_c = level_q + LVL_W'(1);
    else if (!push_c && pop_c) level_n_c = level_q - LVL_W'(1);

    // The entry being written this cycle becomes head when it lands at the new read pointer.
    head_n_c = '0;
    if (level_n_c != '0) begin
      if (push_c && (rd_ptr_n_c == wr_ptr_q)) head_n_c = new_entry_c;
      else                                    head_n_c = mem[rd_ptr_n_c];
    end
  end

  // Control and status registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q   <= 1'b0;
      stamp_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      head_q   <= '0;
    end else begin
      prev_q   <= bus.complete_data;
      stamp_q  <= stamp_q + STAMP_W'(1);
      wr_ptr_q <= wr_ptr_n_c;
      rd_ptr_q <= rd_ptr_n_c;
      level_q  <= level_n_c;
      head_q   <= head_n_c;
      if (drop_c && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clock) begin
    if (reset && push_c) mem[wr_ptr_q] <= new_entry_c;
  end

  assign bus.txn_valid = (level_q != '0);
  assign bus.full      = full_c;
  assign bus.level     = level_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.txn_rd    = head_q.rd;
  assign bus.txn_addr  = head_q.addr;
  assign bus.txn_data  = head_q.data;
  assign bus.txn_stamp = head_q.stamp;
endmodule

// File: tb/tb_data_mem_txn_capture.sv
// Directed bench for data_mem_txn_capture: a queue of expected entries is built as
// stimulus is driven and compared against the FIFO head on every cycle and pop.
module tb_data_mem_txn_capture;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned STAMP_W = 16;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] stamp;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  ent_t        q[$];
  logic        m_prev  = 1'b0;
  logic [15:0] m_stamp = '0;
  logic [15:0] m_drop  = '0;

  data_mem_txn_capture_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W)
  ) bus ();

  data_mem_txn_capture #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("txn_valid", 32'(bus.txn_valid), 32'(q.size() != 0));
    chk("level",     32'(bus.level),     32'(q.size()));
    chk("full",      32'(bus.full),      32'(q.size() == DEPTH));
    chk("drop_cnt",  32'(bus.drop_cnt),  32'(m_drop));
    if (q.size() != 0) begin
      chk("head_rd",    32'(bus.txn_rd),    32'(q[0].rd));
      chk("head_addr",  32'(bus.txn_addr),  32'(q[0].addr));
      chk("head_data",  32'(bus.txn_data),  32'(q[0].data));
      chk("head_stamp", 32'(bus.txn_stamp), 32'(q[0].stamp));
    end
  endtask

  // One clock of stimulus; model updated at drive time, DUT checked after the edge.
  task automatic cycle(input logic cd, input logic rd, input logic [15:0] addr,
                       input logic [15:0] din, input logic [15:0] dout,
                       input logic en, input logic pp);
    ent_t e;
    reset             = 1'b1;
    bus.complete_data = cd;
    bus.Data_rd       = rd;
    bus.Data_addr     = addr;
    bus.Data_din      = din;
    bus.Data_dout     = dout;
    bus.enable        = en;
    bus.pop           = pp;
    if (pp && q.size() != 0) begin
      chk("pop_rd",    32'(bus.txn_rd),    32'(q[0].rd));
      chk("pop_addr",  32'(bus.txn_addr),  32'(q[0].addr));
      chk("pop_data",  32'(bus.txn_data),  32'(q[0].data));
      chk("pop_stamp", 32'(bus.txn_stamp), 32'(q[0].stamp));
      e = q.pop_front();
    end
    if (cd && !m_prev && en) begin
      if (q.size() < DEPTH) begin
        e.rd    = rd;
        e.addr  = addr;
        e.data  = rd ? dout : din;
        e.stamp = m_stamp;
        q.push_back(e);
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end
    m_prev  = cd;
    m_stamp = m_stamp + 16'd1;
    @(posedge clock);
    @(negedge clock);
    check_state();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic pop1();
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
  endtask

  task automatic do_reset(input logic cd, input logic pp);
    reset             = 1'b0;
    bus.complete_data = cd;
    bus.Data_rd       = 1'b1;
    bus.Data_addr     = 16'hDEAD;
    bus.Data_din      = 16'hBEEF;
    bus.Data_dout     = 16'hCAFE;
    bus.enable        = 1'b1;
    bus.pop           = pp;
    q.delete();
    m_prev  = 1'b0;
    m_stamp = '0;
    m_drop  = '0;
    @(posedge clock);
    @(negedge clock);
    check_state();
    chk("rst_txn_rd",    32'(bus.txn_rd),    32'h0);
    chk("rst_txn_addr",  32'(bus.txn_addr),  32'h0);
    chk("rst_txn_data",  32'(bus.txn_data),  32'h0);
    chk("rst_txn_stamp", 32'(bus.txn_stamp), 32'h0);
  endtask

  initial begin
    bus.complete_data = 1'b0;
    bus.Data_rd       = 1'b0;
    bus.Data_addr     = '0;
    bus.Data_din      = '0;
    bus.Data_dout     = '0;
    bus.enable        = 1'b0;
    bus.pop           = 1'b0;

    do_reset(1'b0, 1'b0);
    do_reset(1'b0, 1'b0);

    // Single read sampled while the stamp is 5, strobe held three cycles.
    while (m_stamp != 16'd5) idle();
    repeat (3) cycle(1'b1, 1'b1, 16'h3000, 16'h0000, 16'hABCD, 1'b1, 1'b0);
    chk("rd_level", 32'(bus.level),     32'd1);
    chk("rd_addr",  32'(bus.txn_addr),  32'h3000);
    chk("rd_data",  32'(bus.txn_data),  32'hABCD);
    chk("rd_stamp", 32'(bus.txn_stamp), 32'd5);
    idle();
    pop1();

    // Write captures Data_din, not Data_dout.
    cycle(1'b1, 1'b0, 16'h2000, 16'h1234, 16'hFFFF, 1'b1, 1'b0);
    chk("wr_data", 32'(bus.txn_data), 32'h1234);
    idle();
    pop1();

    // Ten events into an eight-deep FIFO.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'(i % 2), 16'h4000 + 16'(i), 16'h1000 + 16'(i), 16'h8000 + 16'(i), 1'b1, 1'b0);
      idle();
    end
    chk("fill_level", 32'(bus.level),    32'd8);
    chk("fill_full",  32'(bus.full),     32'd1);
    chk("fill_drop",  32'(bus.drop_cnt), 32'd2);
    repeat (8) pop1();
    chk("drain_valid", 32'(bus.txn_valid), 32'd0);

    // Full with simultaneous pop and event, then one dropped event.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 16'h5000 + 16'(i), 16'h2000 + 16'(i), 16'h0, 1'b1, 1'b0);
      idle();
    end
    cycle(1'b1, 1'b1, 16'h6000, 16'h0, 16'h6666, 1'b1, 1'b1);
    chk("pp_level", 32'(bus.level),    32'd8);
    chk("pp_drop",  32'(bus.drop_cnt), 32'd2);
    idle();
    cycle(1'b1, 1'b0, 16'h6100, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("drop3", 32'(bus.drop_cnt), 32'd3);
    idle();
    repeat (7) pop1();
    chk("last_addr", 32'(bus.txn_addr), 32'h6000);
    pop1();

    // Enable gating, including enable rising while the strobe is held high.
    cycle(1'b1, 1'b0, 16'h7000, 16'h0, 16'h0, 1'b0, 1'b0);
    idle();
    chk("gate_off", 32'(bus.level), 32'd0);
    cycle(1'b1, 1'b0, 16'h7100, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 16'h7100, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("gate_held", 32'(bus.level), 32'd0);
    idle();
    cycle(1'b1, 1'b0, 16'h7200, 16'h7272, 16'h0, 1'b1, 1'b0);
    chk("gate_edge", 32'(bus.level), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle();
      cycle(1'b1, 1'b1, 16'h7300 + 16'(i), 16'h0, 16'h7300 + 16'(i), 1'b1, 1'b0);
    end
    chk("pre_rst_level", 32'(bus.level),    32'd5);
    chk("pre_rst_drop",  32'(bus.drop_cnt), 32'd3);

    // Reset mid-run overrides an event and a pop; a later pop on empty is ignored.
    idle();
    do_reset(1'b1, 1'b1);
    pop1();
    chk("post_rst_pop", 32'(bus.level), 32'd0);

    // Strobe already high on the first cycle after reset release counts as an edge.
    do_reset(1'b1, 1'b0);
    cycle(1'b1, 1'b1, 16'h7A00, 16'h0, 16'h5A5A, 1'b1, 1'b1);
    chk("rel_level", 32'(bus.level),     32'd1);
    chk("rel_stamp", 32'(bus.txn_stamp), 32'd0);
    idle();
    pop1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
